// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one synchronous FIFO write port among
// NUM_REQ producers. A requester is granted for a burst of up to MAX_BURST beats; each
// beat is written to the FIFO as {source_id, data}. One idle cycle separates grants.
//
// Optional build macro FIFO_ARB_STATS_EN adds per-requester 16-bit saturating beat
// counters readable through stat_sel/stat_beats and cleared by stat_clr.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   req_valid    per-requester beat valid
//   req_data     flattened payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    per-requester accept (one-hot or zero)
//   fifo_full    downstream FIFO full flag
//   fifo_wr_en   FIFO write strobe
//   fifo_din     {grant_id, payload}, zero when no beat
//   grant_valid  a grant is held
//   grant_id     current or last granted requester
//   stat_sel, stat_clr, stat_beats   (FIFO_ARB_STATS_EN only)
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           fifo_full,
    output logic                           fifo_wr_en,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_din,
    output logic                           grant_valid,
    output logic [ID_WIDTH-1:0]            grant_id
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic [ID_WIDTH-1:0]            stat_sel,
    input  logic                           stat_clr,
    output logic [15:0]                    stat_beats
`endif
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic [ID_WIDTH-1:0]   last_id_q, last_id_d;
    logic [CNT_WIDTH-1:0]  burst_cnt_q, burst_cnt_d;

    logic                  in_grant;
    logic                  cur_valid;
    logic [DATA_WIDTH-1:0] cur_data;
    logic                  beat;
    logic [CNT_WIDTH-1:0]  cnt_inc;

    logic                  found_hi, found_any;
    logic [ID_WIDTH-1:0]   id_hi, id_any, sel_id;

    // Outputs are forced low while rst is asserted, including a mid-burst reset cycle.
    assign in_grant = (state_q == StGrant) && !rst;

    // Mux out the granted requester's valid and payload.
    always_comb begin
        cur_valid = 1'b0;
        cur_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == ID_WIDTH'(i)) begin
                cur_valid = req_valid[i];
                cur_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Round-robin pick: lowest valid index above last_id, else lowest valid index overall
    // (the wrap-around part of the search).
    always_comb begin
        found_hi  = 1'b0;
        found_any = 1'b0;
        id_hi     = '0;
        id_any    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                if (!found_any) begin
                    found_any = 1'b1;
                    id_any    = ID_WIDTH'(i);
                end
                if (!found_hi && (ID_WIDTH'(i) > last_id_q)) begin
                    found_hi = 1'b1;
                    id_hi    = ID_WIDTH'(i);
                end
            end
        end
        sel_id = found_hi ? id_hi : id_any;
    end

    assign beat    = in_grant && cur_valid && !fifo_full;
    assign cnt_inc = burst_cnt_q + CNT_WIDTH'(1);

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = in_grant && !fifo_full && (grant_id_q == ID_WIDTH'(i));
        end
    end

    assign fifo_wr_en  = beat;
    assign fifo_din    = beat ? {grant_id_q, cur_data} : '0;
    assign grant_valid = in_grant;
    assign grant_id    = rst ? '0 : grant_id_q;

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        last_id_d   = last_id_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found_any) begin
                    grant_id_d  = sel_id;
                    burst_cnt_d = '0;
                    state_d     = StGrant;
                end
            end
            StGrant: begin
                if (!cur_valid) begin
                    // Requester dropped valid: forfeit the rest of the burst.
                    last_id_d = grant_id_q;
                    state_d   = StIdle;
                end else if (!fifo_full) begin
                    burst_cnt_d = cnt_inc;
                    if (cnt_inc == CNT_WIDTH'(MAX_BURST)) begin
                        last_id_d = grant_id_q;
                        state_d   = StIdle;
                    end
                end
                // Full with valid held: stall, keep grant and count.
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            grant_id_q  <= '0;
            last_id_q   <= ID_WIDTH'(NUM_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            last_id_q   <= last_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stat_cnt_q [NUM_REQ];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rst || stat_clr) begin
                stat_cnt_q[i] <= '0;
            end else if (beat && (grant_id_q == ID_WIDTH'(i)) && (stat_cnt_q[i] != 16'hFFFF)) begin
                stat_cnt_q[i] <= stat_cnt_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        stat_beats = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (stat_sel == ID_WIDTH'(i)) begin
                stat_beats = stat_cnt_q[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4). Expected FIFO writes
// are queued as each scenario is set up and popped by a monitor on every write strobe.
module tb_fifo_wr_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned DW      = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DW-1:0]     req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_wr_en;
    logic [ID_W+DW-1:0]        fifo_din;
    logic                      grant_valid;
    logic [ID_W-1:0]           grant_id;
`ifdef FIFO_ARB_STATS_EN
    logic [ID_W-1:0]           stat_sel;
    logic                      stat_clr;
    logic [15:0]               stat_beats;
`endif

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .ID_WIDTH  (ID_W),
        .DATA_WIDTH(DW),
        .MAX_BURST (4),
        .CNT_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_clr   (stat_clr),
        .stat_beats (stat_beats)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int wr_count = 0;
    logic [ID_W+DW-1:0] exp_q[$];

    // Producer model: requester i presents base[i] + number of its beats accepted so far.
    logic [7:0] base [NUM_REQ];
    logic [7:0] cnt  [NUM_REQ];
    logic [NUM_REQ-1:0] acc;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DW +: DW] = base[i] + cnt[i];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) if (acc[i]) cnt[i] = cnt[i] + 8'd1;
    endtask

    task automatic push(input int id, input logic [7:0] d);
        exp_q.push_back({2'(id), d});
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (fifo_full) check("no_wr_when_full", {31'b0, fifo_wr_en}, 32'd0);
        if (fifo_wr_en) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {22'b0, fifo_din}, 32'h3ff);
            end else begin
                check("fifo_din", {22'b0, fifo_din}, {22'b0, exp_q.pop_front()});
            end
        end else if (!rst) begin
            check("din_zero_idle", {22'b0, fifo_din}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int steps;
        int wr_before;
        rst = 1'b1;
        fifo_full = 1'b0;
        req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            base[i] = 8'(8'h10 * i);
            cnt[i]  = 8'd0;
        end
`ifdef FIFO_ARB_STATS_EN
        stat_sel = '0;
        stat_clr = 1'b0;
`endif
        // Reset held 3 cycles with all requesters valid.
        #1;
        for (int c = 0; c < 3; c++) begin
            check("rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
            check("rst_ready", {28'b0, req_ready}, 32'd0);
            check("rst_grant_valid", {31'b0, grant_valid}, 32'd0);
            step();
        end
        rst = 1'b0;
        step();
        check("first_grant_valid", {31'b0, grant_valid}, 32'd1);
        check("first_grant_id", {30'b0, grant_id}, 32'd0);

        // Burst and rotation: 4 beats per requester with one bubble between grants.
        for (int i = 0; i < NUM_REQ; i++)
            for (int b = 0; b < 4; b++) push(i, 8'(8'h10 * i + b));
        steps = 0;
        while (exp_q.size() != 0 && steps < 40) begin
            step();
            steps++;
        end
        check("rotation_cycles", steps, 19);
        step();
        check("rotation_back_valid", {31'b0, grant_valid}, 32'd1);
        check("rotation_back_id", {30'b0, grant_id}, 32'd0);
        req_valid = '0;
        step();

        // Early release: requester 2 drops valid after 2 beats.
        base[2] = 8'hAA;
        cnt[2]  = 8'd0;
        push(2, 8'hAA);
        push(2, 8'hAB);
        req_valid = 4'b0100;
        step();
        check("early_grant_id", {30'b0, grant_id}, 32'd2);
        step();
        step();
        req_valid = '0;
        #1;
        check("early_release_cycle_valid", {31'b0, grant_valid}, 32'd1);
        check("early_release_cycle_wr", {31'b0, fifo_wr_en}, 32'd0);
        step();
        check("early_after_release", {31'b0, grant_valid}, 32'd0);
        // last_id=2: with 0 and 3 valid the search visits 3 first.
        req_valid = 4'b1001;
        step();
        check("last_id_is_2", {30'b0, grant_id}, 32'd3);
        req_valid = '0;
        step();

        // Wrap priority: last_id=3, requesters 1 and 3 valid.
        req_valid = 4'b1010;
        step();
        check("wrap_grant_id", {30'b0, grant_id}, 32'd1);

        // Backpressure on requester 1 after its first beat.
        req_valid = 4'b0010;
        base[1] = 8'hB0;
        cnt[1]  = 8'd0;
        for (int b = 0; b < 4; b++) push(1, 8'(8'hB0 + b));
        wr_before = wr_count;
        step();
        fifo_full = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            check("stall_wr_en", {31'b0, fifo_wr_en}, 32'd0);
            check("stall_ready", {28'b0, req_ready}, 32'd0);
            check("stall_grant_valid", {31'b0, grant_valid}, 32'd1);
            check("stall_grant_id", {30'b0, grant_id}, 32'd1);
            step();
        end
        fifo_full = 1'b0;
        for (int c = 0; c < 3; c++) step();
        check("bp_released", {31'b0, grant_valid}, 32'd0);
        check("bp_total_writes", wr_count - wr_before, 32'd4);
        check("bp_queue_drained", exp_q.size(), 32'd0);

        // Reset in the middle of a burst from requester 0.
        base[0] = 8'h50;
        cnt[0]  = 8'd0;
        push(0, 8'h50);
        push(0, 8'h51);
        req_valid = 4'b0001;
        step();
        check("mid_grant_id", {30'b0, grant_id}, 32'd0);
        step();
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
        check("mid_rst_ready", {28'b0, req_ready}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_idle", {31'b0, grant_valid}, 32'd0);
`ifdef FIFO_ARB_STATS_EN
        for (int s = 0; s < NUM_REQ; s++) begin
            stat_sel = 2'(s);
            #1;
            check("stat_after_rst", {16'b0, stat_beats}, 32'd0);
        end
        stat_sel = '0;
`endif
        push(0, 8'h52);
        push(0, 8'h53);
        push(0, 8'h54);
        step();
        for (int c = 0; c < 3; c++) step();
        req_valid = '0;
        step();
`ifdef FIFO_ARB_STATS_EN
        check("stat_three_beats", {16'b0, stat_beats}, 32'd3);
`endif
        push(0, 8'h55);
        req_valid = 4'b0001;
        step();
`ifdef FIFO_ARB_STATS_EN
        stat_clr = 1'b1;
`endif
        step();
`ifdef FIFO_ARB_STATS_EN
        stat_clr = 1'b0;
        #1;
        check("stat_clr_priority", {16'b0, stat_beats}, 32'd0);
`endif
        req_valid = '0;
        step();
        step();
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
